// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side word packer: the FSM state type,
// default ANN datapath geometry and the out_count width helper.
package fifo_pkg;

  // Default geometry: 8-bit FIFO words packed four at a time.
  localparam int ANN_DSIZE = 8;
  localparam int ANN_WORDS = 4;

  // The packer either fills lanes from the FIFO or drains a partial word.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } packer_state_t;

  // out_count has to hold every value from 0 to words, so it is
  // clog2(words+1) bits wide.
  function automatic int count_width(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Packed-word output stream (valid/ready) between the word packer and the
// downstream compute stage. The packer uses the master modport and the
// consumer uses the slave modport.
interface fifo_word_packer_if
  import fifo_pkg::*;
#(
  parameter int DSIZE = ANN_DSIZE,
  parameter int WORDS = ANN_WORDS
);

  localparam int CW = count_width(WORDS);

  logic [DSIZE*WORDS-1:0] out_data;
  logic [CW-1:0]          out_count;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output out_data,
    output out_count,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_count,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fifo_word_packer_out_reg.sv
// packer_out_reg: a valid/ready register slice with a load port. It holds the
// packed word and its lane count until the consumer accepts them, and it
// reports "free" when a new word can be loaded on this edge.
module packer_out_reg
  import fifo_pkg::*;
#(
  parameter  int DSIZE = ANN_DSIZE,
  parameter  int WORDS = ANN_WORDS,
  localparam int CW    = count_width(WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DSIZE*WORDS-1:0] load_data,
  input  logic [CW-1:0]          load_count,
  output logic                   free,
  fifo_word_packer_if.master     out_if
);

  // The slot is free if it is empty or if the word in it leaves on this edge.
  assign free = !out_if.out_valid || out_if.out_ready;

  // Output slot: load a new word, retire one that was accepted, or hold.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) assignments so every flop samples pre-edge values.
    if (rst) begin
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_count <= '0;
    end else if (load) begin
      out_if.out_valid <= 1'b1;
      out_if.out_data  <= load_data;
      out_if.out_count <= load_count;
    end else if (out_if.out_valid && out_if.out_ready) begin
      out_if.out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops DSIZE-bit words from the show-ahead read port of an
// async FIFO and packs WORDS of them into one wide word (first pop in lane 0).
// A flush request emits a partially filled word. The lanes it did not fill
// read as zero.
// Optional feature macro: FIFO_WORD_PACKER_PERF_EN adds the pop_total and
// stall_cycles performance counters.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter  int DSIZE = ANN_DSIZE,
  parameter  int WORDS = ANN_WORDS,
  localparam int CW    = count_width(WORDS)
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic [DSIZE-1:0]   rdata,
  input  logic               rempty,
  output logic               rinc,
  input  logic               flush,
  fifo_word_packer_if.master out_if
`ifdef FIFO_WORD_PACKER_PERF_EN
  ,
  output logic [31:0]        pop_total,
  output logic [31:0]        stall_cycles
`endif
);

  localparam logic [CW-1:0] LAST_LANE  = CW'(WORDS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WORDS);

  packer_state_t          state;
  packer_state_t          state_next;
  logic [CW-1:0]          cnt;
  logic [DSIZE*WORDS-1:0] acc;
  logic                   free;
  logic                   last_pop;
  logic                   flush_load;
  logic                   load;
  logic [DSIZE*WORDS-1:0] load_data;
  logic [CW-1:0]          load_count;

  // Pop decision and FSM next state. The final lane waits for a free output
  // slot. Earlier lanes keep filling while the previous word is stalled.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_next = state;
    rinc       = 1'b0;
    last_pop   = 1'b0;
    flush_load = 1'b0;
    unique case (state)
      ST_FILL: begin
        rinc     = !rrst && !rempty && !flush && !((cnt == LAST_LANE) && !free);
        last_pop = rinc && (cnt == LAST_LANE);
        if (flush) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt == '0) begin
          state_next = ST_FILL;
        end else if (free) begin
          flush_load = 1'b1;
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // A full word takes its last lane straight from rdata. Lane WORDS-1 of acc
  // is always zero at this point, so an OR is enough to merge it.
  assign load       = last_pop || flush_load;
  assign load_data  = last_pop ? (acc | {rdata, {((WORDS - 1) * DSIZE){1'b0}}}) : acc;
  assign load_count = last_pop ? FULL_COUNT : cnt;

  // FSM state register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  // Lane counter and accumulator: clear when a word moves to the output,
  // otherwise write the popped word into lane cnt.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt <= '0;
      // NOTE: the accumulator is reset so that the lanes a flush did not fill read as zero.
      acc <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
    end else if (rinc) begin
      cnt <= cnt + CW'(1);
      for (int i = 0; i < WORDS; i++) begin
        if (cnt == CW'(i)) begin
          acc[i*DSIZE +: DSIZE] <= rdata;
        end
      end
    end
  end

  packer_out_reg #(
    .DSIZE (DSIZE),
    .WORDS (WORDS)
  ) u_out_reg (
    .clk        (rclk),
    .rst        (rrst),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .free       (free),
    .out_if     (out_if)
  );

`ifdef FIFO_WORD_PACKER_PERF_EN
  // Performance counters. Pops wrap. Stall cycles saturate at all ones.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pop_total    <= '0;
      stall_cycles <= '0;
    end else begin
      if (rinc) begin
        pop_total <= pop_total + 32'd1;
      end
      if (!rempty && !rinc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed testbench for fifo_word_packer (DSIZE=8, WORDS=4). A queue models
// the show-ahead FIFO. Accepted output words are captured and compared with
// hand-computed packed values.
module tb_fifo_word_packer;

  localparam int DSIZE = 8;
  localparam int WORDS = 4;

  logic             rclk = 1'b0;
  logic             rrst;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             flush;
  logic             starve;

`ifdef FIFO_WORD_PACKER_PERF_EN
  logic [31:0] pop_total;
  logic [31:0] stall_cycles;
`endif

  fifo_word_packer_if #(.DSIZE(DSIZE), .WORDS(WORDS)) out_if ();

  fifo_word_packer #(.DSIZE(DSIZE), .WORDS(WORDS)) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .rdata        (rdata),
    .rempty       (rempty),
    .rinc         (rinc),
    .flush        (flush),
    .out_if       (out_if)
`ifdef FIFO_WORD_PACKER_PERF_EN
    ,
    .pop_total    (pop_total),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] fq[$];
  logic [31:0]      od_q[$];
  logic [2:0]       oc_q[$];
  int               pops   = 0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the FIFO head and let the combinational rinc settle.
  task automatic settle();
    rempty = (fq.size() == 0) || starve;
    rdata  = (fq.size() != 0) ? fq[0] : '0;
    #1;
  endtask

  // One clock. Call it at a negedge with the inputs already set. It samples
  // rinc and the handshake before the edge and applies them after the edge.
  task automatic cycle();
    logic        take;
    logic        xfer;
    logic [31:0] xd;
    logic [2:0]  xc;
    settle();
    take = rinc;
    xfer = out_if.out_valid && out_if.out_ready && !rrst;
    xd   = out_if.out_data;
    xc   = out_if.out_count;
    @(posedge rclk);
    if (take) begin
      check("pop_while_empty", rempty, 1'b0);
      if (fq.size() != 0) void'(fq.pop_front());
      pops++;
    end
    if (xfer) begin
      od_q.push_back(xd);
      oc_q.push_back(xc);
    end
    @(negedge rclk);
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k = 0;
    while ((od_q.size() < n) && (k < budget)) begin
      cycle();
      k++;
    end
    check({tag, "_done"}, 64'(od_q.size() >= n), 64'd1);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic [2:0] c);
    if (od_q.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_data"}, od_q.pop_front(), d);
      check({tag, "_count"}, oc_q.pop_front(), c);
    end
  endtask

  initial begin
    int base;
    rrst   = 1'b1;
    flush  = 1'b0;
    starve = 1'b0;
    out_if.out_ready = 1'b1;
    @(negedge rclk);

    // Reset: a word is already waiting, but rinc must stay low.
    fq.push_back(8'hEE);
    settle();
    check("rst_rinc", rinc, 1'b0);
    cycle();
    cycle();
    check("rst_valid", out_if.out_valid, 1'b0);
    check("rst_data", out_if.out_data, 32'h0);
    check("rst_count", out_if.out_count, 3'd0);
`ifdef FIFO_WORD_PACKER_PERF_EN
    check("rst_pop_total", pop_total, 32'd0);
`endif
    fq.delete();
    rrst = 1'b0;

    // Basic pack: four consecutive pops, out_valid rises on the 4th pop edge.
    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      settle();
      check("basic_rinc", rinc, 1'b1);
      check("basic_no_valid", out_if.out_valid, 1'b0);
      cycle();
    end
    settle();
    check("basic_valid", out_if.out_valid, 1'b1);
    check("basic_data", out_if.out_data, 32'h44332211);
    check("basic_count", out_if.out_count, 3'd4);
    cycle();
    settle();
    check("basic_valid_drop", out_if.out_valid, 1'b0);
    expect_out("basic", 32'h44332211, 3'd4);

    // Backpressure: seven pops, then the final lane waits behind a held word.
    out_if.out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
    base = pops;
    for (int i = 0; i < 10; i++) cycle();
    check("bp_pops", pops - base, 7);
    settle();
    check("bp_rinc_wait", rinc, 1'b0);
    check("bp_hold_data", out_if.out_data, 32'h04030201);
    cycle();
    check("bp_hold_again", out_if.out_data, 32'h04030201);
    check("bp_hold_valid", out_if.out_valid, 1'b1);
    out_if.out_ready = 1'b1;
    run_until("bp", 3, 30);
    expect_out("bp_w1", 32'h04030201, 3'd4);
    expect_out("bp_w2", 32'h08070605, 3'd4);
    expect_out("bp_w3", 32'h0C0B0A09, 3'd4);
    check("bp_fifo_drained", fq.size(), 0);

    // Flush partial: AA, BB, then flush. The next word starts in lane 0.
    fq = '{8'hAA, 8'hBB};
    cycle();
    cycle();
    fq.push_back(8'hCC);
    flush = 1'b1;
    settle();
    check("fl_rinc_flush", rinc, 1'b0);
    cycle();
    flush = 1'b0;
    settle();
    check("fl_rinc_pend", rinc, 1'b0);
    cycle();
    settle();
    check("fl_valid", out_if.out_valid, 1'b1);
    check("fl_data", out_if.out_data, 32'h0000BBAA);
    check("fl_count", out_if.out_count, 3'd2);
    fq.push_back(8'hDD);
    fq.push_back(8'hEE);
    fq.push_back(8'hFF);
    run_until("fl", 2, 20);
    expect_out("fl_part", 32'h0000BBAA, 3'd2);
    expect_out("fl_next", 32'hFFEEDDCC, 3'd4);

    // Flush with nothing accumulated: one cycle in ST_FLUSH, no output.
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    fq.push_back(8'h01);
    settle();
    check("fe_rinc_pend", rinc, 1'b0);
    cycle();
    settle();
    check("fe_no_valid", out_if.out_valid, 1'b0);
    check("fe_rinc_back", rinc, 1'b1);
    check("fe_no_output", od_q.size(), 0);
    fq.push_back(8'h02);
    fq.push_back(8'h03);
    fq.push_back(8'h04);
    run_until("fe", 1, 20);
    expect_out("fe_word", 32'h04030201, 3'd4);

    // Starved FIFO: rempty toggles every other cycle.
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
    base = pops;
    for (int k = 0; (k < 40) && (od_q.size() < 2); k++) begin
      starve = k[0];
      cycle();
    end
    starve = 1'b0;
    check("st_pops", pops - base, 8);
    expect_out("st_w1", 32'h04030201, 3'd4);
    expect_out("st_w2", 32'h08070605, 3'd4);

    // Reset mid-word: three lanes are discarded, and nothing is popped in the reset cycle.
    fq = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) cycle();
    fq = '{8'h55, 8'h66, 8'h77, 8'h88};
    rrst = 1'b1;
    settle();
    check("mr_rinc", rinc, 1'b0);
    cycle();
    rrst = 1'b0;
    settle();
    check("mr_valid", out_if.out_valid, 1'b0);
    check("mr_data", out_if.out_data, 32'h0);
    check("mr_count", out_if.out_count, 3'd0);
    run_until("mr", 1, 20);
    expect_out("mr_word", 32'h88776655, 3'd4);
`ifdef FIFO_WORD_PACKER_PERF_EN
    check("mr_pop_total", pop_total, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
